// File: rtl/countdown_timer_if.sv
// ---------------------------------------------------------------------------
// countdown_timer_if
//
// Bundles the control inputs and display/status outputs of the game
// time-limit counter.
//
//   btn_origin  start/pause button level (debounced, not edge-detected)
//   load        level: reload the preset time, return to IDLE
//   bonus       one-tick pulse: add 10.0 s
//   tenth, sec0, sec1, min0, min1   BCD digits of MM:SS.t
//   running     timer is counting down
//   expired     timer reached 00:00.0 and is latched there
//   time_up     one-tick pulse when the timer expires
//   warning     low-time indicator
//
// master: the game side (drives controls, reads digits/status)
// slave : the timer itself
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface countdown_timer_if;
  logic       btn_origin;
  logic       load;
  logic       bonus;
  logic [3:0] tenth;
  logic [3:0] sec0;
  logic [3:0] sec1;
  logic [3:0] min0;
  logic [3:0] min1;
  logic       running;
  logic       expired;
  logic       time_up;
  logic       warning;

  modport master (
    output btn_origin, load, bonus,
    input  tenth, sec0, sec1, min0, min1,
    input  running, expired, time_up, warning
  );

  modport slave (
    input  btn_origin, load, bonus,
    output tenth, sec0, sec1, min0, min1,
    output running, expired, time_up, warning
  );
endinterface

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Game time-limit counter. Holds a BCD time MM:SS.t that starts at the
// parameter preset and counts down one tenth per clk_10Hz tick while in RUN.
// A rising edge of the start/pause button toggles IDLE->RUN, RUN<->PAUSE.
// Bonus pulses add 10.0 s (saturating at 59:59.9). Reaching 00:00.0 moves to
// DONE, which is only left through load or rst.
//
// Ports:
//   clk_10Hz  tick clock, one tick = 0.1 s
//   rst       asynchronous, active-high reset (back to preset, IDLE)
//   tmr       countdown_timer_if.slave: controls in, digits/status out
//
// Per-tick priority: load > button edge > bonus/decrement.
// Digit index 0 is tenths, 1 sec0, 2 sec1, 3 min0, 4 min1.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module countdown_timer #(
  parameter int INIT_MIN1 = 0,
  parameter int INIT_MIN0 = 2,
  parameter int INIT_SEC1 = 0,
  parameter int INIT_SEC0 = 0,
  parameter int WARN_SEC  = 10
) (
  input  logic             clk_10Hz,
  input  logic             rst,
  countdown_timer_if.slave tmr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // What happens to the digit registers this tick.
  localparam logic [1:0] OP_HOLD  = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_DEC   = 2'd2;
  localparam logic [1:0] OP_BONUS = 2'd3;

  localparam logic [6:0] WARN_LIM = 7'(WARN_SEC);

  // Largest legal value of each digit position (seconds/minutes tens are 5).
  function automatic logic [3:0] dig_max(input int i);
    return (i == 2 || i == 4) ? 4'd5 : 4'd9;
  endfunction

  // Preset value of each digit position; the tenths preset is always 0.
  function automatic logic [3:0] preset_digit(input int i);
    case (i)
      1:       return 4'(INIT_SEC0);
      2:       return 4'(INIT_SEC1);
      3:       return 4'(INIT_MIN0);
      4:       return 4'(INIT_MIN1);
      default: return 4'd0;
    endcase
  endfunction

  logic [1:0] state_q, state_d;
  logic [1:0] op;
  logic       btn_delay_q;
  logic       btn_edge;
  logic       time_up_q, time_up_d;
  logic       running_q, expired_q;

  logic [3:0] cnt_q   [5];
  logic [3:0] cnt_d   [5];
  logic [3:0] dec_v   [5];
  logic [3:0] add_src [5];
  logic [3:0] inc_v   [5];
  logic [3:0] bonus_v [5];
  logic [4:0] cnt_nz;
  logic [4:0] dec_nz;
  logic       cnt_zero;
  logic       dec_zero;
  logic       inc_ovf;
  logic [6:0] secs;

  assign btn_edge = tmr.btn_origin & ~btn_delay_q;
  assign cnt_zero = ~|cnt_nz;
  assign dec_zero = ~|dec_nz;

  // Subtract one tenth with a BCD borrow chain. A zero count stays zero, so
  // the counter can never wrap below 00:00.0.
  always_comb begin : dec_chain
    logic b;
    b = ~cnt_zero;
    for (int i = 0; i < 5; i++) begin
      dec_v[i] = cnt_q[i];
      if (b) begin
        if (cnt_q[i] == 4'd0) begin
          dec_v[i] = dig_max(i);
        end else begin
          dec_v[i] = cnt_q[i] - 4'd1;
          b        = 1'b0;
        end
      end
    end
  end

  // Add 10.0 s by injecting a carry at sec1. A carry left over after min1
  // means the sum passed 59:59.9 and the result is saturated instead.
  always_comb begin : inc_chain
    logic c;
    c = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inc_v[i] = add_src[i];
      if (i >= 2 && c) begin
        if (add_src[i] == dig_max(i)) begin
          inc_v[i] = 4'd0;
        end else begin
          inc_v[i] = add_src[i] + 4'd1;
          c        = 1'b0;
        end
      end
    end
    inc_ovf = c;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_digit
      assign cnt_nz[gi] = |cnt_q[gi];
      assign dec_nz[gi] = |dec_v[gi];

      // In RUN a bonus lands on the already-decremented value, so that
      // 00:00.1 + bonus becomes 00:10.0 rather than expiring first.
      assign add_src[gi] = (state_q == ST_RUN) ? dec_v[gi] : cnt_q[gi];
      assign bonus_v[gi] = inc_ovf ? dig_max(gi) : inc_v[gi];

      assign cnt_d[gi] = (op == OP_LOAD)  ? preset_digit(gi) :
                         (op == OP_DEC)   ? dec_v[gi]        :
                         (op == OP_BONUS) ? bonus_v[gi]      :
                                            cnt_q[gi];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    time_up_d = 1'b0;
    op        = OP_HOLD;
    if (tmr.load) begin
      op      = OP_LOAD;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (btn_edge) begin
            // A zero preset expires immediately instead of entering RUN.
            if (cnt_zero) begin
              state_d   = ST_DONE;
              time_up_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else if (tmr.bonus) begin
            op = OP_BONUS;
          end
        end
        ST_RUN: begin
          if (btn_edge) begin
            state_d = ST_PAUSE;
          end else if (tmr.bonus) begin
            op = OP_BONUS;
          end else begin
            op = OP_DEC;
            if (dec_zero) begin
              state_d   = ST_DONE;
              time_up_d = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (btn_edge) begin
            state_d = ST_RUN;
          end else if (tmr.bonus) begin
            op = OP_BONUS;
          end
        end
        default: begin
          // DONE: hold at 00:00.0 until load or rst.
        end
      endcase
    end
  end

  always_ff @(posedge clk_10Hz or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      btn_delay_q <= 1'b0;
      time_up_q   <= 1'b0;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= preset_digit(i);
      end
    end else begin
      state_q     <= state_d;
      btn_delay_q <= tmr.btn_origin;
      time_up_q   <= time_up_d;
      running_q   <= (state_d == ST_RUN);
      expired_q   <= (state_d == ST_DONE);
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Whole seconds shown on the sec1/sec0 digits.
  assign secs = 7'({3'd0, cnt_q[2]} * 7'd10) + {3'd0, cnt_q[1]};

  assign tmr.tenth   = cnt_q[0];
  assign tmr.sec0    = cnt_q[1];
  assign tmr.sec1    = cnt_q[2];
  assign tmr.min0    = cnt_q[3];
  assign tmr.min1    = cnt_q[4];
  assign tmr.running = running_q;
  assign tmr.expired = expired_q;
  assign tmr.time_up = time_up_q;
  assign tmr.warning = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) &&
                       (cnt_q[4] == 4'd0) && (cnt_q[3] == 4'd0) &&
                       (secs < WARN_LIM) && !cnt_zero;

endmodule

// File: tb/tb_countdown_timer.sv
`timescale 1ns/1ps
module tb_countdown_timer;

  logic clk_10Hz = 1'b0;
  logic rst      = 1'b1;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  always #5 clk_10Hz = ~clk_10Hz;

  countdown_timer_if if_def ();
  countdown_timer_if if_a ();
  countdown_timer_if if_b ();
  countdown_timer_if if_c ();
  countdown_timer_if if_z ();

  // Defaults: 02:00.0
  countdown_timer u_def (.clk_10Hz(clk_10Hz), .rst(rst), .tmr(if_def));
  // 01:00.0
  countdown_timer #(.INIT_MIN1(0), .INIT_MIN0(1), .INIT_SEC1(0), .INIT_SEC0(0), .WARN_SEC(10))
    u_a (.clk_10Hz(clk_10Hz), .rst(rst), .tmr(if_a));
  // 00:01.0
  countdown_timer #(.INIT_MIN1(0), .INIT_MIN0(0), .INIT_SEC1(0), .INIT_SEC0(1), .WARN_SEC(10))
    u_b (.clk_10Hz(clk_10Hz), .rst(rst), .tmr(if_b));
  // 59:56.0
  countdown_timer #(.INIT_MIN1(5), .INIT_MIN0(9), .INIT_SEC1(5), .INIT_SEC0(6), .WARN_SEC(10))
    u_c (.clk_10Hz(clk_10Hz), .rst(rst), .tmr(if_c));
  // 00:00.0
  countdown_timer #(.INIT_MIN1(0), .INIT_MIN0(0), .INIT_SEC1(0), .INIT_SEC0(0), .WARN_SEC(10))
    u_z (.clk_10Hz(clk_10Hz), .rst(rst), .tmr(if_z));

  // Digits as a 20-bit BCD word MM:SS.t, so 02:00.0 reads as 20'h02000.
  wire [19:0] d_def = {if_def.min1, if_def.min0, if_def.sec1, if_def.sec0, if_def.tenth};
  wire [19:0] d_a   = {if_a.min1, if_a.min0, if_a.sec1, if_a.sec0, if_a.tenth};
  wire [19:0] d_b   = {if_b.min1, if_b.min0, if_b.sec1, if_b.sec0, if_b.tenth};
  wire [19:0] d_c   = {if_c.min1, if_c.min0, if_c.sec1, if_c.sec0, if_c.tenth};
  wire [19:0] d_z   = {if_z.min1, if_z.min0, if_z.sec1, if_z.sec0, if_z.tenth};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_10Hz);
      #1;
    end
  endtask

  task automatic init_inputs();
    if_def.btn_origin = 0; if_def.load = 0; if_def.bonus = 0;
    if_a.btn_origin   = 0; if_a.load   = 0; if_a.bonus   = 0;
    if_b.btn_origin   = 0; if_b.load   = 0; if_b.bonus   = 0;
    if_c.btn_origin   = 0; if_c.load   = 0; if_c.bonus   = 0;
    if_z.btn_origin   = 0; if_z.load   = 0; if_z.bonus   = 0;
  endtask

  task automatic test_reset();
    n_cmp++; if (d_def !== 20'h02000) begin n_bad++; $display("FAIL reset_def_digits: got %h want 02000", d_def); end
    n_cmp++; if (if_def.running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", if_def.running); end
    n_cmp++; if (if_def.expired !== 1'b0) begin n_bad++; $display("FAIL reset_expired: got %b want 0", if_def.expired); end
    n_cmp++; if (if_def.time_up !== 1'b0) begin n_bad++; $display("FAIL reset_time_up: got %b want 0", if_def.time_up); end
    n_cmp++; if (if_def.warning !== 1'b0) begin n_bad++; $display("FAIL reset_warning: got %b want 0", if_def.warning); end
    n_cmp++; if (d_c !== 20'h59560) begin n_bad++; $display("FAIL reset_c_digits: got %h want 59560", d_c); end
    $display("test_reset: compared=%0d mismatched=%0d", n_cmp, n_bad);
  endtask

  task automatic test_start_and_load();
    if_def.btn_origin = 1;
    tick(1);
    n_cmp++; if (d_def !== 20'h02000) begin n_bad++; $display("FAIL start_no_dec: got %h want 02000", d_def); end
    n_cmp++; if (if_def.running !== 1'b1) begin n_bad++; $display("FAIL start_running: got %b want 1", if_def.running); end
    tick(10);
    n_cmp++; if (d_def !== 20'h01590) begin n_bad++; $display("FAIL run_10_ticks: got %h want 01590", d_def); end
    tick(356);
    n_cmp++; if (d_def !== 20'h01234) begin n_bad++; $display("FAIL run_to_01234: got %h want 01234", d_def); end
    if_def.load = 1;
    tick(1);
    if_def.load = 0;
    n_cmp++; if (d_def !== 20'h02000) begin n_bad++; $display("FAIL load_digits: got %h want 02000", d_def); end
    n_cmp++; if (if_def.running !== 1'b0) begin n_bad++; $display("FAIL load_idle: got running=%b want 0", if_def.running); end
    // load together with a fresh button edge: load must win
    if_def.btn_origin = 0;
    tick(1);
    if_def.load = 1; if_def.btn_origin = 1;
    tick(1);
    if_def.load = 0;
    n_cmp++; if (if_def.running !== 1'b0) begin n_bad++; $display("FAIL load_beats_edge: got running=%b want 0", if_def.running); end
    tick(1);
    n_cmp++; if (if_def.running !== 1'b0 || d_def !== 20'h02000) begin
      n_bad++; $display("FAIL held_btn_no_edge: got running=%b digits=%h want 0/02000", if_def.running, d_def); end
    if_def.bonus = 1;
    tick(1);
    if_def.bonus = 0;
    n_cmp++; if (d_def !== 20'h02100) begin n_bad++; $display("FAIL idle_bonus: got %h want 02100", d_def); end
    $display("test_start_and_load: compared=%0d mismatched=%0d", n_cmp, n_bad);
  endtask

  task automatic test_borrow_and_pause();
    if_a.btn_origin = 1;
    tick(1);
    if_a.btn_origin = 0;
    tick(1);
    n_cmp++; if (d_a !== 20'h00599) begin n_bad++; $display("FAIL borrow_chain: got %h want 00599", d_a); end
    tick(294);
    n_cmp++; if (d_a !== 20'h00305) begin n_bad++; $display("FAIL run_to_00305: got %h want 00305", d_a); end
    if_a.btn_origin = 1;
    tick(1);
    if_a.btn_origin = 0;
    n_cmp++; if (if_a.running !== 1'b0 || d_a !== 20'h00305) begin
      n_bad++; $display("FAIL pause_enter: got running=%b digits=%h want 0/00305", if_a.running, d_a); end
    tick(20);
    n_cmp++; if (d_a !== 20'h00305 || if_a.warning !== 1'b0) begin
      n_bad++; $display("FAIL pause_frozen: got digits=%h warning=%b want 00305/0", d_a, if_a.warning); end
    if_a.btn_origin = 1;
    tick(1);
    if_a.btn_origin = 0;
    n_cmp++; if (if_a.running !== 1'b1 || d_a !== 20'h00305) begin
      n_bad++; $display("FAIL resume: got running=%b digits=%h want 1/00305", if_a.running, d_a); end
    tick(1);
    n_cmp++; if (d_a !== 20'h00304) begin n_bad++; $display("FAIL resume_dec: got %h want 00304", d_a); end
    $display("test_borrow_and_pause: compared=%0d mismatched=%0d", n_cmp, n_bad);
  endtask

  task automatic test_expire();
    if_b.btn_origin = 1;
    tick(1);
    if_b.btn_origin = 0;
    n_cmp++; if (if_b.warning !== 1'b1) begin n_bad++; $display("FAIL warn_at_start: got %b want 1", if_b.warning); end
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      n_cmp++; if (d_b !== {16'h0000, 4'(10 - k)} || if_b.warning !== 1'b1 || if_b.time_up !== 1'b0) begin
        n_bad++; $display("FAIL expire_tick%0d: got digits=%h warn=%b tu=%b want %h/1/0",
                          k, d_b, if_b.warning, if_b.time_up, {16'h0000, 4'(10 - k)}); end
    end
    tick(1);
    n_cmp++; if (d_b !== 20'h00000 || if_b.time_up !== 1'b1 || if_b.expired !== 1'b1 ||
                 if_b.warning !== 1'b0 || if_b.running !== 1'b0) begin
      n_bad++; $display("FAIL expire_done: got digits=%h tu=%b exp=%b warn=%b run=%b want 00000/1/1/0/0",
                        d_b, if_b.time_up, if_b.expired, if_b.warning, if_b.running); end
    tick(1);
    n_cmp++; if (if_b.time_up !== 1'b0 || if_b.expired !== 1'b1) begin
      n_bad++; $display("FAIL time_up_one_tick: got tu=%b exp=%b want 0/1", if_b.time_up, if_b.expired); end
    if_b.btn_origin = 1; if_b.bonus = 1;
    tick(1);
    if_b.btn_origin = 0; if_b.bonus = 0;
    tick(1);
    n_cmp++; if (d_b !== 20'h00000 || if_b.expired !== 1'b1 || if_b.time_up !== 1'b0) begin
      n_bad++; $display("FAIL done_ignores: got digits=%h exp=%b tu=%b want 00000/1/0", d_b, if_b.expired, if_b.time_up); end
    $display("test_expire: compared=%0d mismatched=%0d", n_cmp, n_bad);
  endtask

  task automatic test_bonus_run_edge();
    if_b.load = 1;
    tick(1);
    if_b.load = 0;
    n_cmp++; if (d_b !== 20'h00010 || if_b.expired !== 1'b0) begin
      n_bad++; $display("FAIL reload_from_done: got digits=%h exp=%b want 00010/0", d_b, if_b.expired); end
    if_b.btn_origin = 1;
    tick(1);
    if_b.btn_origin = 0;
    tick(9);
    n_cmp++; if (d_b !== 20'h00001) begin n_bad++; $display("FAIL run_to_00001: got %h want 00001", d_b); end
    if_b.bonus = 1;
    tick(1);
    if_b.bonus = 0;
    n_cmp++; if (d_b !== 20'h00100 || if_b.time_up !== 1'b0 || if_b.running !== 1'b1) begin
      n_bad++; $display("FAIL bonus_at_00001: got digits=%h tu=%b run=%b want 00100/0/1", d_b, if_b.time_up, if_b.running); end
    tick(1);
    n_cmp++; if (d_b !== 20'h00099) begin n_bad++; $display("FAIL after_bonus_dec: got %h want 00099", d_b); end
    $display("test_bonus_run_edge: compared=%0d mismatched=%0d", n_cmp, n_bad);
  endtask

  task automatic test_bonus_saturate();
    if_c.btn_origin = 1;
    tick(1);
    if_c.btn_origin = 0;
    tick(10);
    if_c.btn_origin = 1;
    tick(1);
    if_c.btn_origin = 0;
    n_cmp++; if (d_c !== 20'h59550 || if_c.running !== 1'b0) begin
      n_bad++; $display("FAIL pause_at_59550: got digits=%h run=%b want 59550/0", d_c, if_c.running); end
    if_c.bonus = 1;
    tick(1);
    if_c.bonus = 0;
    n_cmp++; if (d_c !== 20'h59599) begin n_bad++; $display("FAIL bonus_saturate: got %h want 59599", d_c); end
    $display("test_bonus_saturate: compared=%0d mismatched=%0d", n_cmp, n_bad);
  endtask

  task automatic test_zero_preset();
    if_z.btn_origin = 1;
    tick(1);
    n_cmp++; if (if_z.time_up !== 1'b1 || if_z.expired !== 1'b1 || if_z.running !== 1'b0 || d_z !== 20'h00000) begin
      n_bad++; $display("FAIL zero_start: got tu=%b exp=%b run=%b digits=%h want 1/1/0/00000",
                        if_z.time_up, if_z.expired, if_z.running, d_z); end
    tick(1);
    n_cmp++; if (if_z.time_up !== 1'b0) begin n_bad++; $display("FAIL zero_pulse_len: got %b want 0", if_z.time_up); end
    $display("test_zero_preset: compared=%0d mismatched=%0d", n_cmp, n_bad);
  endtask

  task automatic test_async_reset();
    tick(1);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (d_a !== 20'h01000 || if_a.running !== 1'b0) begin
      n_bad++; $display("FAIL async_rst_a: got digits=%h run=%b want 01000/0", d_a, if_a.running); end
    n_cmp++; if (d_c !== 20'h59560 || if_z.expired !== 1'b0) begin
      n_bad++; $display("FAIL async_rst_others: got c=%h zexp=%b want 59560/0", d_c, if_z.expired); end
    tick(2);
    rst = 1'b0;
    $display("test_async_reset: compared=%0d mismatched=%0d", n_cmp, n_bad);
  endtask

  initial begin
    init_inputs();
    tick(2);
    rst = 1'b0;
    test_reset();
    test_start_and_load();
    test_borrow_and_pause();
    test_expire();
    test_bonus_run_edge();
    test_bonus_saturate();
    test_zero_preset();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
